// File: rtl/hamming_link_ctrl.sv
// hamming_link_ctrl
//
// Two-requester Hamming(7,4) link controller. Both requesters share one
// encode/check pipeline through a round-robin arbiter. Each word is handled
// in four steps:
//   IDLE (accept) -> ENC (encode, apply channel mask) -> CHK (syndrome, correct)
//   -> OUT (hold result until out_ready).
// The controller is single-error-correcting only. A double-bit error is
// miscorrected and is reported only through out_corrected.
//
// Codeword layout: cw[6:0] = {d3, d2, d1, p2, d0, p1, p0}
//   p0 = d0^d1^d3, p1 = d0^d2^d3, p2 = d1^d2^d3
//
// Configuration macro: HLC_ERR_INJECT_EN
//   defined   : the err_mask port exists and is XORed into the codeword in ENC.
//   undefined : there is no err_mask port and the channel is clean, so the
//               syndrome is always zero, out_corrected stays 0 and corr_cnt
//               stays 0.
//
// Ports
//   clk, reset               single clock; synchronous active-high reset
//   in0_valid/data/ready     requester 0 handshake, 4-bit data word
//   in1_valid/data/ready     requester 1 handshake, 4-bit data word
//   err_mask[6:0]            channel error-injection mask (HLC_ERR_INJECT_EN only)
//   out_valid/out_ready      result handshake
//   out_data[3:0]            corrected data bits {d3,d2,d1,d0}
//   out_code[6:0]            corrected codeword
//   out_parity[2:0]          corrected parity bits {p2,p1,p0}
//   out_src                  requester that owns the result
//   out_corrected            syndrome was nonzero
//   corr_cnt[CNT_W-1:0]      saturating count of corrected words

module hamming_link_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_valid,
  input  logic [3:0]       in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [3:0]       in1_data,
  output logic             in1_ready,
`ifdef HLC_ERR_INJECT_EN
  input  logic [6:0]       err_mask,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [6:0]       out_code,
  output logic [2:0]       out_parity,
  output logic             out_src,
  output logic             out_corrected,
  output logic [CNT_W-1:0] corr_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEnc  = 2'd1,
    StChk  = 2'd2,
    StOut  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [6:0] hlc_encode(input logic [3:0] d);
    logic p0, p1, p2;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p2, d[0], p1, p0};
  endfunction

  // Channel mask. It is tied to zero when error injection is not built in.
  logic [6:0] chan_mask;
`ifdef HLC_ERR_INJECT_EN
  assign chan_mask = err_mask;
`else
  assign chan_mask = 7'b0;
`endif

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;   // requester granted most recently
  logic [3:0]       data_q, data_d;
  logic             src_q, src_d;
  logic [6:0]       code_q, code_d;
  logic [3:0]       out_data_q, out_data_d;
  logic [6:0]       out_code_q, out_code_d;
  logic [2:0]       out_parity_q, out_parity_d;
  logic             out_src_q, out_src_d;
  logic             out_corrected_q, out_corrected_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

  // Arbitration. When both requesters are valid, the one not granted last
  // wins. Ready depends on valid, so at most one ready is ever high.
  logic grant_idx;
  logic accept;

  always_comb begin
    grant_idx = 1'b0;
    if (in0_valid && in1_valid) begin
      grant_idx = ~rr_last_q;
    end else begin
      grant_idx = in1_valid;
    end
  end

  // Ready is gated with reset so that no handshake is offered in a reset cycle.
  assign in0_ready = (state_q == StIdle) && !reset && in0_valid && (grant_idx == 1'b0);
  assign in1_ready = (state_q == StIdle) && !reset && in1_valid && (grant_idx == 1'b1);
  assign accept    = in0_ready || in1_ready;

  // Syndrome and single-bit correction of the registered codeword.
  logic [2:0] syn;
  logic [6:0] flip;
  logic [6:0] fixed_code;

  always_comb begin
    syn[0] = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
    syn[1] = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
    syn[2] = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
    flip   = 7'b0;
    if (syn != 3'd0) begin
      // The syndrome gives the 1-based position of the bit in error.
      flip[syn - 3'd1] = 1'b1;
    end
    fixed_code = code_q ^ flip;
  end

  // Next-state logic
  always_comb begin
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    data_d          = data_q;
    src_d           = src_q;
    code_d          = code_q;
    out_data_d      = out_data_q;
    out_code_d      = out_code_q;
    out_parity_d    = out_parity_q;
    out_src_d       = out_src_q;
    out_corrected_d = out_corrected_q;
    corr_cnt_d      = corr_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d    = in1_ready ? in1_data : in0_data;
          src_d     = in1_ready;
          rr_last_d = in1_ready;
          state_d   = StEnc;
        end
      end
      StEnc: begin
        code_d  = hlc_encode(data_q) ^ chan_mask;
        state_d = StChk;
      end
      StChk: begin
        out_code_d      = fixed_code;
        out_data_d      = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
        out_parity_d    = {fixed_code[3], fixed_code[1], fixed_code[0]};
        out_src_d       = src_q;
        out_corrected_d = (syn != 3'd0);
        // The counter is updated on entry to OUT, so it already holds the new
        // value in the cycle where out_valid rises.
        if ((syn != 3'd0) && (corr_cnt_q != CntMax)) begin
          corr_cnt_d = corr_cnt_q + CntOne;
        end
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      rr_last_q       <= 1'b1;  // requester 0 wins the first contested grant
      data_q          <= 4'b0;
      src_q           <= 1'b0;
      code_q          <= 7'b0;
      out_data_q      <= 4'b0;
      out_code_q      <= 7'b0;
      out_parity_q    <= 3'b0;
      out_src_q       <= 1'b0;
      out_corrected_q <= 1'b0;
      corr_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      data_q          <= data_d;
      src_q           <= src_d;
      code_q          <= code_d;
      out_data_q      <= out_data_d;
      out_code_q      <= out_code_d;
      out_parity_q    <= out_parity_d;
      out_src_q       <= out_src_d;
      out_corrected_q <= out_corrected_d;
      corr_cnt_q      <= corr_cnt_d;
    end
  end

  assign out_valid     = (state_q == StOut);
  assign out_data      = out_data_q;
  assign out_code      = out_code_q;
  assign out_parity    = out_parity_q;
  assign out_src       = out_src_q;
  assign out_corrected = out_corrected_q;
  assign corr_cnt      = corr_cnt_q;

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Self-checking bench for hamming_link_ctrl. Expected results are pushed to a
// scoreboard queue when a word is driven, then popped and compared when the
// output handshake occurs. HLC_ERR_INJECT_EN selects whether the err_mask
// port is connected.

module tb_hamming_link_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic [3:0] in0_data, in1_data;
  logic [6:0] err_mask_r;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [6:0] out_code;
  logic [2:0] out_parity;
  logic       out_src, out_corrected;
  logic [7:0] corr_cnt;

  always #5 clk = ~clk;

  hamming_link_ctrl #(
    .CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in0_valid    (in0_valid),
    .in0_data     (in0_data),
    .in0_ready    (in0_ready),
    .in1_valid    (in1_valid),
    .in1_data     (in1_data),
    .in1_ready    (in1_ready),
`ifdef HLC_ERR_INJECT_EN
    .err_mask     (err_mask_r),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_code     (out_code),
    .out_parity   (out_parity),
    .out_src      (out_src),
    .out_corrected(out_corrected),
    .corr_cnt     (corr_cnt)
  );

  typedef struct {
    logic       src;
    logic [3:0] data;
    logic [6:0] code;
    logic [2:0] par;
    logic       corr;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rr_last  = 1'b1;
  int   exp_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] tb_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [6:0] eff_mask(input logic [6:0] m);
`ifdef HLC_ERR_INJECT_EN
    return m;
`else
    return 7'b0;
`endif
  endfunction

  function automatic logic [23:0] out_pack();
    return {out_data, out_code, out_parity, out_src, out_corrected, corr_cnt};
  endfunction

  // Scoreboard consumer: compares on the cycle that completes the handshake.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_src", 32'(out_src), 32'(e.src));
        check_eq("out_code", 32'(out_code), 32'(e.code));
        check_eq("out_data", 32'(out_data), 32'(e.data));
        check_eq("out_parity", 32'(out_parity), 32'(e.par));
        check_eq("out_corrected", 32'(out_corrected), 32'(e.corr));
        check_eq("corr_cnt", 32'(corr_cnt), 32'(e.cnt));
      end
    end
  end

  // Drives one word. The task is called at posedge+1 with the DUT in IDLE.
  task automatic send(input logic v0, input logic [3:0] d0, input logic v1,
                      input logic [3:0] d1, input logic [6:0] m, input int hold);
    logic       g;
    logic [3:0] d;
    logic [6:0] c;
    logic [2:0] s;
    int         idx;
    int         waited;
    int         lat;
    logic [23:0] snap;
    exp_t       e;

    g       = (v0 && v1) ? ~rr_last : v1;
    rr_last = g;
    d       = g ? d1 : d0;
    c       = tb_encode(d) ^ eff_mask(m);
    s[0]    = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1]    = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2]    = c[3] ^ c[4] ^ c[5] ^ c[6];
    if (s != 3'd0) begin
      idx    = int'(s) - 1;
      c[idx] = ~c[idx];
      if (exp_cnt < 255) exp_cnt++;
    end
    e.src  = g;
    e.code = c;
    e.data = {c[6], c[5], c[4], c[2]};
    e.par  = {c[3], c[1], c[0]};
    e.corr = (s != 3'd0);
    e.cnt  = 8'(exp_cnt);
    sb.push_back(e);

    in0_valid  = v0;
    in0_data   = d0;
    in1_valid  = v1;
    in1_data   = d1;
    err_mask_r = ~m;  // the mask is not sampled in IDLE
    #1;
    waited = 0;
    while (!(in0_ready || in1_ready) && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("accept_wait", 32'(waited), 32'd0);
    check_eq("grant", 32'({in1_ready, in0_ready}), g ? 32'd2 : 32'd1);
    @(posedge clk);  // accept edge
    #1;
    // Data is captured only at the accept edge, so these changes must not
    // affect the result.
    in0_valid  = 1'b0;
    in1_valid  = 1'b0;
    in0_data   = ~d0;
    in1_data   = ~d1;
    err_mask_r = m;
    @(posedge clk);  // ENC edge, where the mask is sampled
    #1;
    err_mask_r = ~m;
    lat = 2;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd3);

    snap      = out_pack();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_stable", 32'(out_pack()), 32'(snap));
      check_eq("hold_ready", 32'({in1_ready, in0_ready}), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);  // handshake edge
    #1;
    out_ready = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check_eq("valid_drop", 32'(out_valid), 32'd0);
  endtask

  logic [3:0] pat [4];

  initial begin
    reset      = 1'b1;
    in0_valid  = 1'b1;
    in1_valid  = 1'b1;
    in0_data   = 4'h0;
    in1_data   = 4'h0;
    err_mask_r = 7'b0;
    out_ready  = 1'b0;

    // Reset state. Ready must stay low while reset is high.
    @(posedge clk);
    #1;
    check_eq("rst_ready", 32'({in1_ready, in0_ready}), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_outs", 32'(out_pack()), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;

    // Clean word from requester 0.
    send(1'b1, 4'b1011, 1'b0, 4'b0000, 7'b0, 0);
    // Requester 1 with a single-bit error on cw[4].
    send(1'b0, 4'b0000, 1'b1, 4'b1011, 7'b0010000, 0);
    // Both requesters valid: grants alternate starting with requester 0.
    pat[0] = 4'b0000;
    pat[1] = 4'b1111;
    pat[2] = 4'b0001;
    pat[3] = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) send(1'b1, pat[k], 1'b1, ~pat[k], 7'b0, 0);
      else            send(1'b1, ~pat[k], 1'b1, pat[k], 7'b0, 0);
    end
    // Backpressure for 10 cycles.
    send(1'b1, 4'b0110, 1'b0, 4'b0000, 7'b0, 10);
    // Double-bit error is miscorrected as a single-bit error.
    send(1'b1, 4'b0110, 1'b0, 4'b0000, 7'b0000011, 0);
    // Random traffic with random single-bit or clean masks.
    for (int k = 0; k < 10; k++) begin
      int          r;
      logic [6:0]  m;
      r = $urandom_range(1, 3);
      m = ($urandom_range(0, 1) == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'b0;
      send(r[0], 4'($urandom_range(0, 15)), r[1], 4'($urandom_range(0, 15)), m,
           $urandom_range(0, 2));
    end
    // Counter saturation.
    for (int k = 0; k < 258; k++) begin
      send(1'b1, 4'(k), 1'b0, 4'b0000, 7'(1 << (k % 7)), 0);
    end
    check_eq("cnt_sat", 32'(corr_cnt), 32'(exp_cnt));

    // Reset while in CHK aborts the word.
    in0_valid  = 1'b1;
    in0_data   = 4'b0101;
    err_mask_r = 7'b0000001;
    #1;
    check_eq("abort_ready", 32'(in0_ready), 32'd1);
    @(posedge clk);  // accept edge
    #1;
    in0_valid = 1'b0;
    @(posedge clk);  // ENC edge, DUT now in CHK
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    rr_last = 1'b1;
    exp_cnt = 0;
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_cnt", 32'(corr_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_out", 32'(out_valid), 32'd0);
    end
    send(1'b1, 4'b1001, 1'b1, 4'b0110, 7'b0, 0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
